// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM states and helpers for the iterative multiply/divide unit.
// Op-code predicates live here so the top and any decoder agree on classification.
package muldiv_pkg;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

    // Sliced down to the instance width where used.
    localparam int                   MAX_WIDTH = 64;
    localparam logic [MAX_WIDTH-1:0] DIV0_LO   = '1;

    function automatic logic is_iter_op(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Execute-stage <-> mul/div sequencer bundle: request side plus status and HI/LO.
interface muldiv_if #(parameter int WIDTH = 32);

    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op, a, b, input  busy, done, hi, lo);
    modport slave  (input  start, op, a, b, output busy, done, hi, lo);

endinterface

// File: rtl/muldiv_iter.sv
// Unsigned shift-add multiply / restoring divide datapath, one iteration per step.
// Both algorithms share the acc:lo shift pair; acc ends as product-high or remainder.
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a_mag,
    input  logic [WIDTH-1:0] b_mag,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] lo_q,  lo_d;
    logic [WIDTH-1:0] m_q,   m_d;
    logic             div_q, div_d;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             ge;

    always_comb begin
        acc_d   = acc_q;
        lo_d    = lo_q;
        m_d     = m_q;
        div_d   = div_q;
        sum     = {1'b0, acc_q} + (lo_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});
        shifted = {acc_q, lo_q[WIDTH-1]};
        diff    = shifted[WIDTH-1:0] - m_q;
        ge      = (shifted >= {1'b0, m_q});

        // Multiply keeps the multiplier in lo; divide keeps the dividend there.
        if (load) begin
            acc_d = '0;
            div_d = is_div;
            m_d   = is_div ? b_mag : a_mag;
            lo_d  = is_div ? a_mag : b_mag;
        end else if (step) begin
            if (div_q) begin
                acc_d = ge ? diff : shifted[WIDTH-1:0];
                lo_d  = {lo_q[WIDTH-2:0], ge};
            end else begin
                acc_d = sum[WIDTH:1];
                lo_d  = {sum[0], lo_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            lo_q  <= '0;
            m_q   <= '0;
            div_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            lo_q  <= lo_d;
            m_q   <= m_d;
            div_q <= div_d;
        end
    end

    assign res_hi = acc_q;
    assign res_lo = lo_q;

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle multiply/divide sequencer owning HI/LO: IDLE -> CALC (WIDTH steps) -> FIX.
// Signs are stripped at accept and restored in FIX; the iterator only sees magnitudes.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst,
    muldiv_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;
    logic [WIDTH-1:0] hi_q,    hi_d;
    logic [WIDTH-1:0] lo_q,    lo_d;
    logic [2:0]       op_q,    op_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic             div0_q,    div0_d;

    logic             accept;
    logic             iter_go;
    logic             signed_op;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    assign accept    = bus.start && !busy_q;
    assign iter_go   = accept && is_iter_op(bus.op);
    assign signed_op = is_signed_op(bus.op);
    assign a_mag     = (signed_op && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign b_mag     = (signed_op && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk    (clk),
        .rst    (rst),
        .load   (iter_go),
        .step   (state_q == ST_CALC),
        .is_div (is_div_op(bus.op)),
        .a_mag  (a_mag),
        .b_mag  (b_mag),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

    // Remainder takes the dividend's sign, which also returns a unchanged on divide by zero.
    assign prod_fix = neg_res_q ? -{res_hi, res_lo} : {res_hi, res_lo};
    assign quo_fix  = neg_res_q ? -res_lo : res_lo;
    assign rem_fix  = neg_rem_q ? -res_hi : res_hi;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;
        op_d      = op_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (bus.op == OP_MTHI) begin
                        hi_d = bus.a;
                    end else if (bus.op == OP_MTLO) begin
                        lo_d = bus.a;
                    end else if (is_iter_op(bus.op)) begin
                        state_d   = ST_CALC;
                        cnt_d     = '0;
                        busy_d    = 1'b1;
                        op_d      = bus.op;
                        neg_res_d = signed_op && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        neg_rem_d = signed_op && bus.a[WIDTH-1];
                        div0_d    = (bus.b == '0);
                    end
                end
            end
            ST_CALC: begin
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = ST_FIX;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                if (is_div_op(op_q)) begin
                    lo_d = div0_q ? DIV0_LO[WIDTH-1:0] : quo_fix;
                    hi_d = rem_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            op_q      <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            op_q      <= op_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule
